// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: divider defaults, state encoding
// and the byte-wide data bus type used for rx_data and the shift register.
package uart_rx_pkg;

    localparam int UART_DIV_RATE   = 260;
    localparam int UART_DIV_CNT_W  = 9;
    localparam int UART_RX_STATE_W = 2;
    localparam int BYTE_DATA_W     = 8;

    typedef logic [BYTE_DATA_W-1:0] byte_data_bus_t;

    typedef enum logic [UART_RX_STATE_W-1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs. The reset value is a
// parameter so idle-high lines come out of reset without a false edge.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Two back-to-back flops give the first stage a full cycle to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is synchronized, a falling edge starts a frame,
// the start bit is confirmed at mid-bit and every following bit is sampled one
// bit period later. A good stop bit publishes the byte with rx_end; a bad one
// pulses rx_err and leaves rx_data untouched.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DIV_RATE  = UART_DIV_RATE,
    parameter int DIV_CNT_W = UART_DIV_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    output logic                   rx_busy,
    output logic                   rx_end,
    output logic                   rx_err,
    output logic [BYTE_DATA_W-1:0] rx_data
);

    localparam logic [DIV_CNT_W-1:0] HALF_LAST = DIV_CNT_W'(DIV_RATE / 2 - 1);
    localparam logic [DIV_CNT_W-1:0] BIT_LAST  = DIV_CNT_W'(DIV_RATE - 1);

    logic           rx_s;
    logic           rx_s_d_reg;
    rx_state_t      state_reg,   state_next;
    logic [DIV_CNT_W-1:0] div_cnt_reg, div_cnt_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    byte_data_bus_t shift_reg,   shift_next;
    byte_data_bus_t data_reg,    data_next;
    logic           end_reg,     end_next;
    logic           err_reg,     err_next;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s_d_reg  <= 1'b1;
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            data_reg    <= '0;
            end_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            rx_s_d_reg  <= rx_s;
            state_reg   <= state_next;
            div_cnt_reg <= div_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            data_reg    <= data_next;
            end_reg     <= end_next;
            err_reg     <= err_next;
        end
    end

    // Next-state logic: the divider runs freely inside a state and is cleared
    // at each sample point and on every state change, so it never wraps.
    always_comb begin
        state_next   = state_reg;
        div_cnt_next = div_cnt_reg + DIV_CNT_W'(1);
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        data_next    = data_reg;
        end_next     = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                div_cnt_next = '0;
                // Edge-triggered so a line stuck low cannot start frames.
                if (rx_s_d_reg && !rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (div_cnt_reg == HALF_LAST) begin
                    div_cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end else begin
                        // Line already back high: treat it as a glitch.
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (div_cnt_reg == BIT_LAST) begin
                    div_cnt_next = '0;
                    shift_next   = {rx_s, shift_reg[BYTE_DATA_W-1:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (div_cnt_reg == BIT_LAST) begin
                    div_cnt_next = '0;
                    state_next   = IDLE;
                    if (rx_s) begin
                        data_next = shift_reg;
                        end_next  = 1'b1;
                    end else begin
                        err_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_busy = (state_reg != IDLE);
    assign rx_end  = end_reg;
    assign rx_err  = err_reg;
    assign rx_data = data_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clk per bit. Each segment records the driven line
// and the DUT outputs cycle by cycle; afterwards a sampling model derived from
// the frame timing (edge, mid-start check, samples every bit period, stop
// sample 152 clk after the edge) predicts busy/end/err/data for every cycle.
module tb_uart_rx;

    localparam int DIV  = 16;
    localparam int MAXC = 4096;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic       rx_busy;
    logic       rx_end;
    logic       rx_err;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    uart_rx #(
        .DIV_RATE  (DIV),
        .DIV_CNT_W (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_busy (rx_busy),
        .rx_end  (rx_end),
        .rx_err  (rx_err),
        .rx_data (rx_data)
    );

    logic        line_a [MAXC];
    logic [10:0] obs_a  [MAXC];
    logic [10:0] exp_a  [MAXC];
    bit          e_busy [MAXC];
    bit          e_end  [MAXC];
    bit          e_err  [MAXC];
    logic [7:0]  e_val  [MAXC];

    int  ncyc   = 0;
    bit  rec_on = 1'b0;
    int  n_cmp  = 0;
    int  n_bad  = 0;
    int  seg_id = 0;

    logic [7:0] exp_bytes [$];
    int         exp_errs;

    // Record the line level and DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (rec_on && ncyc < MAXC) begin
            line_a[ncyc] <= rx;
            obs_a[ncyc]  <= {rx_busy, rx_end, rx_err, rx_data};
            ncyc         <= ncyc + 1;
        end
    end

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            rx = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int bl, input logic stop_v);
        drive(1'b0, bl);
        for (int k = 0; k < 8; k++) drive(b[k], bl);
        drive(stop_v, bl);
    endtask

    // Hold reset, confirm all outputs are zero, then start a new segment.
    task automatic do_reset();
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        assert ({rx_busy, rx_end, rx_err, rx_data} === 11'h000)
        else begin
            n_bad++;
            $error("FAIL reset_outputs: observed busy/end/err/data=%b/%b/%b/%h expected 0/0/0/00",
                   rx_busy, rx_end, rx_err, rx_data);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        ncyc   = 0;
        rec_on = 1'b1;
        seg_id++;
    endtask

    // Predict outputs for n recorded cycles from the line waveform alone.
    task automatic build_expect(input int n);
        int         j;
        logic       prev;
        logic [7:0] b;
        logic [7:0] cur;
        for (int c = 0; c < n; c++) begin
            e_busy[c] = 1'b0;
            e_end[c]  = 1'b0;
            e_err[c]  = 1'b0;
            e_val[c]  = 8'h00;
        end
        j = 0;
        while (j < n) begin
            prev = (j == 0) ? 1'b1 : line_a[j-1];
            if (prev && !line_a[j]) begin
                if (j + 8 < n && line_a[j+8]) begin
                    for (int c = j + 3; c <= j + 10 && c < n; c++) e_busy[c] = 1'b1;
                    $display("seg %0d: false start at cycle %0d", seg_id, j);
                    j += 9;
                end else begin
                    for (int c = j + 3; c <= j + 154 && c < n; c++) e_busy[c] = 1'b1;
                    if (j + 155 < n) begin
                        for (int k = 0; k < 8; k++) b[k] = line_a[j + 8 + DIV * (k + 1)];
                        if (line_a[j+152]) begin
                            e_end[j+155] = 1'b1;
                            e_val[j+155] = b;
                            $display("seg %0d: frame at cycle %0d -> byte %h, rx_end", seg_id, j, b);
                        end else begin
                            e_err[j+155] = 1'b1;
                            $display("seg %0d: frame at cycle %0d -> bad stop, rx_err", seg_id, j);
                        end
                    end else begin
                        $display("seg %0d: frame at cycle %0d cut off by segment end", seg_id, j);
                    end
                    j += 153;
                end
            end else begin
                j++;
            end
        end
        cur = 8'h00;
        for (int c = 0; c < n; c++) begin
            if (e_end[c]) cur = e_val[c];
            exp_a[c] = {e_busy[c], e_end[c], e_err[c], cur};
        end
    endtask

    // Close the segment and compare every recorded cycle with the model.
    task automatic end_segment();
        rec_on = 1'b0;
        build_expect(ncyc);
        for (int c = 0; c < ncyc; c++) begin
            n_cmp++;
            assert (obs_a[c] === exp_a[c])
            else begin
                n_bad++;
                $error("FAIL seg%0d_cycle%0d: observed busy/end/err/data=%b/%b/%b/%h expected %b/%b/%b/%h",
                       seg_id, c, obs_a[c][10], obs_a[c][9], obs_a[c][8], obs_a[c][7:0],
                       exp_a[c][10], exp_a[c][9], exp_a[c][8], exp_a[c][7:0]);
            end
        end
    endtask

    // Compare pulses seen in the last segment with a directed byte list.
    task automatic check_pulses();
        logic [7:0] got [$];
        int         errs;
        errs = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (obs_a[c][9]) got.push_back(obs_a[c][7:0]);
            if (obs_a[c][8]) errs++;
        end
        n_cmp++;
        assert (got.size() === exp_bytes.size())
        else begin
            n_bad++;
            $error("FAIL seg%0d_end_count: observed %0d expected %0d", seg_id, got.size(), exp_bytes.size());
        end
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++) begin
            n_cmp++;
            assert (got[i] === exp_bytes[i])
            else begin
                n_bad++;
                $error("FAIL seg%0d_byte%0d: observed %h expected %h", seg_id, i, got[i], exp_bytes[i]);
            end
        end
        n_cmp++;
        assert (errs === exp_errs)
        else begin
            n_bad++;
            $error("FAIL seg%0d_err_count: observed %0d expected %0d", seg_id, errs, exp_errs);
        end
    endtask

    initial begin
        int         bl;
        int         gap;
        logic       stop_v;
        logic [7:0] b;

        @(posedge clk);
        #1;

        // Good frame, back-to-back pair, glitch, bad stop with line held low.
        do_reset();
        drive(1'b1, 10);
        send_frame(8'h55, DIV, 1'b1);
        drive(1'b1, 20);
        send_frame(8'hA5, DIV, 1'b1);
        send_frame(8'h3C, DIV, 1'b1);
        drive(1'b1, 20);
        drive(1'b0, 3);
        drive(1'b1, 40);
        send_frame(8'hFF, DIV, 1'b0);
        drive(1'b0, 500);
        drive(1'b1, 30);
        end_segment();
        exp_bytes = '{8'h55, 8'hA5, 8'h3C};
        exp_errs  = 1;
        check_pulses();

        // Reset in the middle of bit 4 of a 0x81 frame: nothing may come out.
        do_reset();
        drive(1'b1, 10);
        drive(1'b0, DIV);
        drive(1'b1, DIV);
        drive(1'b0, 3 * DIV);
        drive(1'b0, DIV / 2);
        end_segment();
        exp_bytes = {};
        exp_errs  = 0;
        check_pulses();

        // Clean 0x81 after that reset.
        do_reset();
        drive(1'b1, 10);
        send_frame(8'h81, DIV, 1'b1);
        drive(1'b1, 20);
        end_segment();
        exp_bytes = '{8'h81};
        exp_errs  = 0;
        check_pulses();

        // Fast line: at 15 clk/bit the drift reaches the last data bits, so the
        // expected byte comes only from the sampling model.
        do_reset();
        drive(1'b1, 10);
        send_frame(8'h96, 15, 1'b1);
        drive(1'b1, 30);
        end_segment();

        // Slow line at 17 clk/bit.
        do_reset();
        drive(1'b1, 10);
        send_frame(8'h96, 17, 1'b1);
        drive(1'b1, 30);
        end_segment();
        exp_bytes = '{8'h96};
        exp_errs  = 0;
        check_pulses();

        // Random bytes, bit lengths, stop validity and idle gaps.
        do_reset();
        drive(1'b1, 10);
        for (int f = 0; f < 8; f++) begin
            b      = 8'($urandom_range(0, 255));
            bl     = $urandom_range(15, 17);
            stop_v = ($urandom_range(0, 3) != 0);
            gap    = $urandom_range(0, 24);
            send_frame(b, bl, stop_v);
            drive(1'b1, gap);
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, $urandom_range(1, 6));
                drive(1'b1, 12);
            end
        end
        drive(1'b1, 200);
        end_segment();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
